// File: rtl/io_bus_controller.sv
// rtl/io_bus_controller.sv - memory-mapped stream/GPIO controller for the RV32E data bus
module io_bus_controller #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] gpio_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] OFF_STREAM = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_GPIO   = 2'd2;

  // Input FIFO state
  logic [31:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Output skid register and GPIO
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [31:0]   gpio_q, gpio_d;

  // Decode and handshake terms
  logic          in_window;
  logic [1:0]    offset;
  logic          fifo_empty;
  logic          fifo_full;
  logic          rd_stream;
  logic          wr_stream;
  logic          wr_gpio;
  logic          pop;
  logic          push;
  logic          out_accept;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  // Byte lanes are ignored: every access is treated as a full word.
  assign unused_addr_bits = ^mem_addr[1:0];

  assign in_window  = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset     = mem_addr[3:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  assign rd_stream  = mem_req && !mem_we && in_window && (offset == OFF_STREAM);
  assign wr_stream  = mem_req &&  mem_we && in_window && (offset == OFF_STREAM);
  assign wr_gpio    = mem_req &&  mem_we && in_window && (offset == OFF_GPIO);

  // in_ready depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop        = rd_stream && !fifo_empty;
  assign out_accept = wr_stream && (!out_valid_q || out_ready);

  assign status_word = {25'd0, 5'(count_q), out_valid_q, !fifo_empty};

  // Stall only when a stream access cannot complete this cycle.
  assign mem_stall = (rd_stream && fifo_empty) || (wr_stream && !out_accept);

  // Load data mux; unmapped, idle and blocked stream reads return zero.
  always_comb begin
    mem_rdata = 32'd0;
    if (mem_req && !mem_we && in_window) begin
      case (offset)
        OFF_STREAM: mem_rdata = fifo_empty ? 32'd0 : fifo_mem_q[rd_ptr_q];
        OFF_STATUS: mem_rdata = status_word;
        OFF_GPIO:   mem_rdata = gpio_q;
        default:    mem_rdata = 32'd0;
      endcase
    end
  end

  // FIFO pointer and occupancy next state; push+pop leaves occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output register next state: a store refills it, a handshake without a store drains it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    gpio_d      = gpio_q;
    if (out_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_wdata;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (wr_gpio) begin
      gpio_d = mem_wdata;
    end
  end

  // FIFO storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control state with asynchronous reset; reset drops any buffered input and pending output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      gpio_q      <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      gpio_q      <= gpio_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// tb/tb_io_bus_controller.sv - directed vector bench for io_bus_controller
module tb_io_bus_controller;

  localparam logic [31:0] S  = 32'h0000_1000;
  localparam logic [31:0] ST = 32'h0000_1004;
  localparam logic [31:0] G  = 32'h0000_1008;
  localparam logic [31:0] U  = 32'h0000_100C;
  localparam logic [31:0] O  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] gpio_out;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        iv;
    logic [31:0] idata;
    logic        ordy;
    logic [31:0] e_rdata;
    logic        e_stall;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [31:0] e_gpio;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  io_bus_controller #(
    .FIFO_DEPTH(4),
    .BASE_ADDR (32'h0000_1000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_stall(mem_stall),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gpio_out (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic req, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic iv, input logic [31:0] idata,
                     input logic ordy, input logic [31:0] e_rdata, input logic e_stall,
                     input logic e_irdy, input logic e_ov, input logic [31:0] e_od,
                     input logic [31:0] e_gpio);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.iv = iv; v.idata = idata; v.ordy = ordy;
    v.e_rdata = e_rdata; v.e_stall = e_stall; v.e_irdy = e_irdy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_gpio = e_gpio;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic iv, input logic [31:0] idata,
                       input logic ordy);
    mem_req = req; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    in_valid = iv; in_data = idata; out_ready = ordy;
  endtask

  initial begin
    // req we addr wdata iv idata ordy | rdata stall irdy ov od gpio
    add(1, 0, ST, 0, 1, 32'hAA, 0,   32'h0,  0, 1, 0, 0, 0);  // 0 first cycle after reset
    add(1, 0, S,  0, 0, 0,      0,   32'hAA, 0, 1, 0, 0, 0);  // 1 reset-edge push visible
    add(0, 0, 0,  0, 1, 32'h7,  0,   32'h0,  0, 1, 0, 0, 0);  // 2
    add(0, 0, 0,  0, 1, 32'h9,  0,   32'h0,  0, 1, 0, 0, 0);  // 3
    add(1, 0, S,  0, 0, 0,      0,   32'h7,  0, 1, 0, 0, 0);  // 4
    add(1, 0, S,  0, 0, 0,      0,   32'h9,  0, 1, 0, 0, 0);  // 5
    add(1, 0, S,  0, 0, 0,      0,   32'h0,  1, 1, 0, 0, 0);  // 6 empty -> stall
    add(1, 0, S,  0, 1, 32'h5,  0,   32'h0,  1, 1, 0, 0, 0);  // 7 push edge, still stall
    add(1, 0, S,  0, 0, 0,      0,   32'h5,  0, 1, 0, 0, 0);  // 8
    add(0, 0, 0,  0, 1, 32'h11, 0,   32'h0,  0, 1, 0, 0, 0);  // 9
    add(0, 0, 0,  0, 1, 32'h22, 0,   32'h0,  0, 1, 0, 0, 0);  // 10
    add(0, 0, 0,  0, 1, 32'h33, 0,   32'h0,  0, 1, 0, 0, 0);  // 11
    add(0, 0, 0,  0, 1, 32'h44, 0,   32'h0,  0, 1, 0, 0, 0);  // 12
    add(1, 0, ST, 0, 1, 32'h55, 0,   32'h11, 0, 0, 0, 0, 0);  // 13 full
    add(1, 0, S,  0, 1, 32'h55, 0,   32'h11, 0, 0, 0, 0, 0);  // 14 pop while full, no push
    add(1, 0, S,  0, 1, 32'h66, 0,   32'h22, 0, 1, 0, 0, 0);  // 15 push+pop
    add(1, 0, ST, 0, 0, 0,      0,   32'h0D, 0, 1, 0, 0, 0);  // 16
    add(1, 0, S,  0, 0, 0,      0,   32'h33, 0, 1, 0, 0, 0);  // 17
    add(1, 0, S,  0, 0, 0,      0,   32'h44, 0, 1, 0, 0, 0);  // 18
    add(1, 0, S,  0, 0, 0,      0,   32'h66, 0, 1, 0, 0, 0);  // 19
    add(1, 0, ST, 0, 0, 0,      0,   32'h0,  0, 1, 0, 0, 0);  // 20
    add(1, 1, S,  1, 0, 0,      0,   32'h0,  0, 1, 0, 0, 0);  // 21 store accepted
    add(1, 1, S,  0, 0, 0,      0,   32'h0,  1, 1, 1, 1, 0);  // 22 blocked
    add(1, 1, S,  0, 0, 0,      1,   32'h0,  0, 1, 1, 1, 0);  // 23 out_ready frees it
    add(0, 0, 0,  0, 0, 0,      0,   32'h0,  0, 1, 1, 0, 0);  // 24
    add(1, 0, ST, 0, 0, 0,      1,   32'h2,  0, 1, 1, 0, 0);  // 25 drain
    add(0, 0, 0,  0, 0, 0,      0,   32'h0,  0, 1, 0, 0, 0);  // 26
    add(1, 1, S,  32'hA, 0, 0,  1,   32'h0,  0, 1, 0, 0, 0);  // 27 back-to-back
    add(1, 1, S,  32'hB, 0, 0,  1,   32'h0,  0, 1, 1, 32'hA, 0);  // 28
    add(1, 1, S,  32'hC, 0, 0,  1,   32'h0,  0, 1, 1, 32'hB, 0);  // 29
    add(0, 0, 0,  0, 0, 0,      1,   32'h0,  0, 1, 1, 32'hC, 0);  // 30
    add(0, 0, 0,  0, 0, 0,      0,   32'h0,  0, 1, 0, 32'hC, 0);  // 31
    add(1, 1, G,  1, 0, 0,      0,   32'h0,  0, 1, 0, 32'hC, 0);  // 32
    add(1, 1, G,  0, 0, 0,      0,   32'h0,  0, 1, 0, 32'hC, 1);  // 33
    add(1, 0, G,  0, 0, 0,      0,   32'h0,  0, 1, 0, 32'hC, 0);  // 34
    add(1, 1, 32'h100A, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, 1, 0, 32'hC, 0);           // 35
    add(1, 0, G,  0, 0, 0,      0,   32'hDEADBEEF, 0, 1, 0, 32'hC, 32'hDEADBEEF);  // 36
    add(1, 1, U,  32'h1234, 0, 0, 0, 32'h0,  0, 1, 0, 32'hC, 32'hDEADBEEF);        // 37
    add(1, 1, 32'h2008, 32'h5555, 0, 0, 0, 32'h0, 0, 1, 0, 32'hC, 32'hDEADBEEF);   // 38
    add(1, 1, ST, 32'h77, 1, 32'h99, 0, 32'h0, 0, 1, 0, 32'hC, 32'hDEADBEEF);     // 39
    add(1, 0, U,  0, 0, 0,      0,   32'h0,  0, 1, 0, 32'hC, 32'hDEADBEEF);        // 40
    add(1, 0, O,  0, 0, 0,      0,   32'h0,  0, 1, 0, 32'hC, 32'hDEADBEEF);        // 41
    add(1, 0, 32'h1003, 0, 0, 0, 0,  32'h99, 0, 1, 0, 32'hC, 32'hDEADBEEF);        // 42
    add(1, 0, ST, 0, 0, 0,      0,   32'h0,  0, 1, 0, 32'hC, 32'hDEADBEEF);        // 43

    // Reset held with in_valid asserted: nothing may be captured.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 32'hAA, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_gpio", gpio_out, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
            vecs[i].iv, vecs[i].idata, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_stall", i), {31'd0, mem_stall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_irdy});
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
      chk($sformatf("v%0d_gpio", i), gpio_out, vecs[i].e_gpio);
    end

    // Build up 3 buffered inputs and a pending output word, then reset between edges.
    @(negedge clk);
    drive(1, 1, S, 32'h42, 1, 32'h1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h2, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h3, 0);
    @(negedge clk);
    drive(1, 0, ST, 0, 0, 0, 0);
    #1;
    chk("pre_rst_status", mem_rdata, 32'h0F);
    chk("pre_rst_out_data", out_data, 32'h42);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_data", out_data, 32'd0);
    chk("async_rst_gpio", gpio_out, 32'd0);
    chk("async_rst_status", mem_rdata, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, S, 0, 0, 0, 0);
    #1;
    chk("post_rst_stream_empty_stall", {31'd0, mem_stall}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bus_controller.md
Name: io_bus_controller

Overview:
- Memory-mapped I/O controller between the RV32E core's data bus and the external world.
- Decodes core load/store accesses into three functions:
  - a buffered input stream (FIFO fed by a valid/ready handshake);
  - a buffered output stream (one-entry skid register with valid/ready);
  - a GPIO output register.
- Stalls the core when a stream access cannot complete, so programs read input with LW and write output with SW at fixed addresses.

Parameters:
- FIFO_DEPTH, 4, input FIFO entries (power of two, 2..16).
- BASE_ADDR, 32'h0000_0000, byte base of the I/O window (aligned to 16 bytes).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  in  1  core data access valid this cycle.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  byte address from core.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data (combinational).
- mem_stall  out  1  core must hold its access and retry.
- in_data  in  32  external input word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept.
- out_data  out  32  external output word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- gpio_out  out  32  GPIO register.

Behaviour:
- Address decode:
  - Only mem_addr[31:4] == BASE_ADDR[31:4] is decoded; bits [1:0] are ignored (forced word access).
  - Offsets by mem_addr[3:2]:
    - 0 = STREAM.
    - 1 = STATUS.
    - 2 = GPIO.
    - 3 = unmapped.
  - Addresses outside the window are unmapped.
- Unmapped read: mem_rdata = 0. Unmapped write: ignored. Neither stalls.
- STREAM read:
  - FIFO non-empty: mem_rdata = FIFO head in the same cycle, mem_stall = 0, and the head pops on the next clk edge.
  - FIFO empty: mem_stall = 1, mem_rdata = 0, no state change.
- STREAM write:
  - Accepted when out_valid == 0 or out_ready == 1 in the same cycle. On the edge: out_data <= mem_wdata, out_valid <= 1.
  - Otherwise mem_stall = 1 and out_data holds.
  - Back-to-back stores with out_ready held high sustain one word per cycle.
- Output drain: out_valid && out_ready with no accepted store clears out_valid on the edge. out_data holds its last value.
- STATUS read, no stall:
  - bit0 = FIFO non-empty.
  - bit1 = out_valid.
  - bits[6:2] = FIFO occupancy, 0..FIFO_DEPTH.
  - all other bits 0.
- STATUS write: ignored.
- GPIO:
  - Write: gpio_out <= mem_wdata on the edge, no stall.
  - Read: returns gpio_out.
- Input FIFO push:
  - in_ready = !full, derived from registered occupancy (no combinational path from a same-cycle pop).
  - Push on the edge when in_valid && in_ready.
- Simultaneous push and pop: occupancy unchanged, data order preserved.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is one bit wider than the pointers.
- mem_stall is purely combinational from mem_req, mem_we, decode and current state. It is 0 when mem_req == 0.
- Reset (asynchronous assert, synchronous deassert assumed by the system):
  - FIFO emptied, pointers = 0.
  - out_valid = 0, out_data = 0, gpio_out = 0.
  - in_ready = 1, mem_stall = 0 when idle.
- Reset mid-transfer discards FIFO contents and any pending output word. No partial state survives.
- Latency:
  - input word to core-visible: 1 cycle after the push edge;
  - store to out_valid: 1 cycle.

Test Plan:
- Reset with in_valid = 1, then release -> out_valid = 0, gpio_out = 0, STATUS read = 0 on the first cycle, in_ready = 1; the first push lands on the first edge after release.
- Push 7 then 9 through in_valid; core LW STREAM twice -> rdata 7 then 9, no stall. A third LW stalls until 5 is pushed, then returns 5 on the cycle after the push edge.
- Push 4 words with FIFO_DEPTH = 4 -> in_ready = 0 and STATUS = 0x11. A fifth in_valid is not accepted. A pop plus a simultaneous push in the same cycle is not possible while full; on the next cycle in_ready = 1, and a push with a concurrent pop keeps STATUS = 0x0D.
- SW STREAM 0x1, then SW 0x0, with out_ready = 0 -> first store accepted (out_valid = 1, out_data = 1), second stalls. Raise out_ready -> out_data = 0 on the next edge, stall drops in the same cycle.
- SW GPIO 0x1, then SW GPIO 0x0, then LW GPIO -> gpio_out pulses 1 for one store interval, readback 0. SW to offset 3 and to an address outside the window -> no state change, no stall, reads return 0.
- Assert rst_n low mid-drain (out_valid = 1, FIFO holding 3 words) -> out_valid, occupancy and gpio_out are 0 immediately, without waiting for clk.
